// File: rtl/mmio_responder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : mmio_responder_pkg                                              |
// | Purpose : Shared constants for the MMIO responder: register offsets,      |
// |           FSM state encoding, CTRL/STATUS bit positions and the decode    |
// |           helper.                                                         |
// | Ports   : none (package)                                                  |
// | Revision: 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
package mmio_responder_pkg;

  // Register offsets within the 64-byte window
  localparam logic [5:0] OFF_LED     = 6'h00;
  localparam logic [5:0] OFF_SCRATCH = 6'h04;
  localparam logic [5:0] OFF_TIMER   = 6'h08;
  localparam logic [5:0] OFF_CTRL    = 6'h0C;
  localparam logic [5:0] OFF_COMPARE = 6'h10;
  localparam logic [5:0] OFF_STATUS  = 6'h14;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // CTRL / STATUS bit positions
  localparam int CTRL_TEN     = 0;
  localparam int CTRL_IEN     = 1;
  localparam int STATUS_MATCH = 0;

  // Anything above STATUS (0x18..0x3C) is a hole in the map
  function automatic logic off_unmapped(input logic [5:0] off);
    return off > OFF_STATUS;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_responder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : mmio_responder_if                                               |
// | Purpose : Processor data-bus request/response bundle.                     |
// | Signals : Req/WE/Adr/WD driven by the master; RD/Ready/Err returned by    |
// |           the slave.                                                      |
// | Revision: 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
interface mmio_responder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  Req;
  logic                  WE;
  logic [ADDR_WIDTH-1:0] Adr;
  logic [DATA_WIDTH-1:0] WD;
  logic [DATA_WIDTH-1:0] RD;
  logic                  Ready;
  logic                  Err;

  modport master (output Req, WE, Adr, WD, input RD, Ready, Err);
  modport slave  (input Req, WE, Adr, WD, output RD, Ready, Err);
endinterface
`default_nettype wire

// File: rtl/mmio_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : mmio_timer                                                      |
// | Purpose : Free-running timer with compare register and sticky MATCH flag. |
// | Ports   : clk, rst_n (async, active low); en = TEN; load/load_val =      |
// |           software TIMER write; cmp_load/cmp_val = COMPARE write;         |
// |           match_clr = write-1-to-clear of MATCH; timer/compare/match out. |
// | Revision: 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module mmio_timer #(
  parameter int WIDTH = 32
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             en,
  input  wire logic             load,
  input  wire logic [WIDTH-1:0] load_val,
  input  wire logic             cmp_load,
  input  wire logic [WIDTH-1:0] cmp_val,
  input  wire logic             match_clr,
  output logic      [WIDTH-1:0] timer,
  output logic      [WIDTH-1:0] compare,
  output logic                  match
);

  // Match is judged on the pre-update timer value, so a same-cycle load
  // or compare write never hides a hit.
  logic hit;
  assign hit = en && (timer == compare);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer   <= '0;
      compare <= '0;
      match   <= 1'b0;
    end else begin
      if (load)
        timer <= load_val;
      else if (en)
        timer <= timer + WIDTH'(1);

      if (cmp_load)
        compare <= cmp_val;

      // Setting beats a simultaneous clear
      if (hit)
        match <= 1'b1;
      else if (match_clr)
        match <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mmio_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : mmio_responder                                                  |
// | Purpose : Memory-mapped register responder (LED, scratch, timer) with     |
// |           req/ready handshake and configurable wait states.               |
// | Ports   : CLK, RST (async active low); bus = slave side of the data bus;  |
// |           test[7:0] = LED register; Irq = MATCH & IEN.                    |
// | Revision: 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module mmio_responder
  import mmio_responder_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 'h100,
  parameter int                    WAIT_STATES = 1
) (
  input  wire logic         CLK,
  input  wire logic         RST,
  mmio_responder_if.slave   bus,
  output logic      [7:0]   test,
  output logic              Irq
);

  logic [1:0]            state;
  logic [3:0]            wait_cnt;
  logic [ADDR_WIDTH-1:0] lat_adr;
  logic                  lat_we;
  logic [DATA_WIDTH-1:0] lat_wd;
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  err_q;

  logic [7:0]            led;
  logic [DATA_WIDTH-1:0] scratch;
  logic                  ten;
  logic                  ien;

  logic [DATA_WIDTH-1:0] timer_val;
  logic [DATA_WIDTH-1:0] compare_val;
  logic                  match;

  // With zero wait states RESP is entered on the acceptance edge, before the
  // latches hold the request, so decode looks at the live bus in IDLE.
  logic [ADDR_WIDTH-1:0] acc_adr;
  logic                  acc_we;
  logic [5:0]            offset;
  logic                  in_window;
  logic                  acc_err;
  logic                  enter_resp;
  logic [DATA_WIDTH-1:0] rd_mux;

  assign acc_adr   = (state == ST_IDLE) ? bus.Adr : lat_adr;
  assign acc_we    = (state == ST_IDLE) ? bus.WE  : lat_we;
  assign offset    = acc_adr[5:0];
  // Base is 64-byte aligned, so the window test is an upper-bit compare
  assign in_window = (acc_adr[ADDR_WIDTH-1:6] == BASE_ADDR[ADDR_WIDTH-1:6]);
  assign acc_err   = !in_window || (offset[1:0] != 2'b00) || off_unmapped(offset);

  assign enter_resp = ((state == ST_IDLE) && bus.Req && (WAIT_STATES == 0)) ||
                      ((state == ST_WAIT) && (wait_cnt == 4'd1));

  always_comb begin
    rd_mux = '0;
    case (offset)
      OFF_LED:     rd_mux[7:0] = led;
      OFF_SCRATCH: rd_mux = scratch;
      OFF_TIMER:   rd_mux = timer_val;
      OFF_CTRL: begin
        rd_mux[CTRL_TEN] = ten;
        rd_mux[CTRL_IEN] = ien;
      end
      OFF_COMPARE: rd_mux = compare_val;
      OFF_STATUS:  rd_mux[STATUS_MATCH] = match;
      default:     rd_mux = '0;
    endcase
  end

  // Handshake FSM and registered response
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      lat_adr  <= '0;
      lat_we   <= 1'b0;
      lat_wd   <= '0;
      rd_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.Req) begin
            lat_adr  <= bus.Adr;
            lat_we   <= bus.WE;
            lat_wd   <= bus.WD;
            wait_cnt <= 4'(WAIT_STATES);
            state    <= (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1)
            state <= ST_RESP;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      // RD/Err live only for the RESP cycle; writes and errors return zero
      if (enter_resp) begin
        err_q <= acc_err;
        rd_q  <= (acc_err || acc_we) ? '0 : rd_mux;
      end else begin
        err_q <= 1'b0;
        rd_q  <= '0;
      end
    end
  end

  // Write commit at the end of RESP; err_q is valid throughout RESP
  logic commit;
  assign commit = (state == ST_RESP) && lat_we && !err_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      led     <= '0;
      scratch <= '0;
      ten     <= 1'b0;
      ien     <= 1'b0;
    end else if (commit) begin
      case (lat_adr[5:0])
        OFF_LED:     led <= lat_wd[7:0];
        OFF_SCRATCH: scratch <= lat_wd;
        OFF_CTRL: begin
          ten <= lat_wd[CTRL_TEN];
          ien <= lat_wd[CTRL_IEN];
        end
        default: ;
      endcase
    end
  end

  mmio_timer #(
    .WIDTH (DATA_WIDTH)
  ) u_timer (
    .clk       (CLK),
    .rst_n     (RST),
    .en        (ten),
    .load      (commit && (lat_adr[5:0] == OFF_TIMER)),
    .load_val  (lat_wd),
    .cmp_load  (commit && (lat_adr[5:0] == OFF_COMPARE)),
    .cmp_val   (lat_wd),
    .match_clr (commit && (lat_adr[5:0] == OFF_STATUS) && lat_wd[STATUS_MATCH]),
    .timer     (timer_val),
    .compare   (compare_val),
    .match     (match)
  );

  assign bus.Ready = (state == ST_RESP);
  assign bus.RD    = rd_q;
  assign bus.Err   = err_q;
  assign test      = led;
  assign Irq       = match & ien;

endmodule
`default_nettype wire

// File: tb/tb_mmio_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_mmio_responder                                               |
// | Purpose : Scoreboard bench for mmio_responder; dut0 has one wait state,   |
// |           dut1 has none.                                                  |
// | Revision: 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_mmio_responder;

  logic       clk;
  logic       rst_n;
  logic [7:0] test0, test1;
  logic       irq0, irq1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [31:0] rd;
    logic        err;
    bit          chk_rd;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  mmio_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus0 ();
  mmio_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus1 ();

  mmio_responder #(.WAIT_STATES(1)) dut0 (
    .CLK(clk), .RST(rst_n), .bus(bus0.slave), .test(test0), .Irq(irq0)
  );
  mmio_responder #(.WAIT_STATES(0)) dut1 (
    .CLK(clk), .RST(rst_n), .bus(bus1.slave), .test(test1), .Irq(irq1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input bit r, input bit w,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel == 0) begin
      bus0.Req = r; bus0.WE = w; bus0.Adr = a; bus0.WD = d;
    end else begin
      bus1.Req = r; bus1.WE = w; bus1.Adr = a; bus1.WD = d;
    end
  endtask

  function automatic bit rdy(input int sel);
    return (sel == 0) ? bus0.Ready : bus1.Ready;
  endfunction

  // Called at a negedge; returns at the negedge of the cycle after Ready
  task automatic access(input int sel, input bit w, input logic [31:0] adr,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input bit exp_err, input string tag);
    exp_t e;
    int   cyc;
    e.tag = tag; e.rd = exp_rd; e.err = exp_err; e.chk_rd = !w;
    if (sel == 0) q0.push_back(e); else q1.push_back(e);
    drive(sel, 1'b1, w, adr, wd);
    @(negedge clk);
    drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc = 1;
    while (!rdy(sel) && cyc < 16) begin
      @(negedge clk);
      cyc++;
    end
    if (!rdy(sel))
      check({tag, "_timeout"}, 32'd0, 32'd1);
    else
      check({tag, "_latency"}, 32'(cyc), (sel == 0) ? 32'd2 : 32'd1);
    @(negedge clk);
  endtask

  // Scoreboard monitors: every Ready must match a queued expectation
  always @(negedge clk) begin
    if (bus0.Ready === 1'b1) begin
      if (q0.size() == 0) check("unexpected_ready0", 32'd1, 32'd0);
      else begin
        e0 = q0.pop_front();
        if (e0.chk_rd) check({e0.tag, "_rd"}, bus0.RD, e0.rd);
        check({e0.tag, "_err"}, {31'd0, bus0.Err}, {31'd0, e0.err});
      end
    end
  end

  always @(negedge clk) begin
    if (bus1.Ready === 1'b1) begin
      if (q1.size() == 0) check("unexpected_ready1", 32'd1, 32'd0);
      else begin
        e1 = q1.pop_front();
        if (e1.chk_rd) check({e1.tag, "_rd"}, bus1.RD, e1.rd);
        check({e1.tag, "_err"}, {31'd0, bus1.Err}, {31'd0, e1.err});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_test", {24'd0, test0}, 32'd0);
    check("rst_ready", {31'd0, bus0.Ready}, 32'd0);
    check("rst_irq", {31'd0, irq0}, 32'd0);
    check("rst_rd", bus0.RD, 32'd0);

    // LED / scratch
    access(0, 0, 32'h100, 0, 32'h0, 0, "rd_led_rst");
    access(0, 1, 32'h100, 32'hDEAD_BEA5, 0, 0, "wr_led");
    check("led_pins", {24'd0, test0}, 32'hA5);
    access(0, 0, 32'h100, 0, 32'h0000_00A5, 0, "rd_led");
    access(0, 1, 32'h104, 32'h1234_5678, 0, 0, "wr_scr");
    access(0, 0, 32'h104, 0, 32'h1234_5678, 0, "rd_scr");

    // Timer compare, MATCH, Irq
    access(0, 1, 32'h110, 32'd10, 0, 0, "wr_cmp");
    access(0, 1, 32'h10C, 32'd1, 0, 0, "wr_ctrl1");
    repeat (15) @(negedge clk);
    access(0, 0, 32'h114, 0, 32'd1, 0, "rd_status");
    check("irq_ien0", {31'd0, irq0}, 32'd0);
    access(0, 1, 32'h10C, 32'd3, 0, 0, "wr_ctrl3");
    check("irq_on", {31'd0, irq0}, 32'd1);
    access(0, 1, 32'h114, 32'd1, 0, 0, "w1c");
    check("irq_off", {31'd0, irq0}, 32'd0);
    access(0, 0, 32'h10C, 0, 32'd3, 0, "rd_ctrl");
    access(0, 1, 32'h108, 32'hFFFF_FFFF, 0, 0, "wr_tmr_max");
    access(0, 0, 32'h108, 0, 32'h0, 0, "rd_tmr_wrap");
    access(0, 1, 32'h10C, 32'd0, 0, 0, "wr_ctrl0");
    access(0, 1, 32'h108, 32'h0000_0ABC, 0, 0, "wr_tmr");
    access(0, 0, 32'h108, 0, 32'h0000_0ABC, 0, "rd_tmr_held");

    // Error responses
    access(0, 0, 32'h102, 0, 32'h0, 1, "rd_misal");
    access(0, 0, 32'h118, 0, 32'h0, 1, "rd_unmap");
    access(0, 0, 32'h200, 0, 32'h0, 1, "rd_outwin");
    access(0, 1, 32'h118, 32'hFFFF_FFFF, 0, 1, "wr_unmap");
    access(0, 1, 32'h140, 32'h0000_0011, 0, 1, "wr_outwin");
    access(0, 0, 32'h100, 0, 32'h0000_00A5, 0, "rd_led_kept");
    access(0, 0, 32'h104, 0, 32'h1234_5678, 0, "rd_scr_kept");
    access(0, 0, 32'h10C, 0, 32'h0, 0, "rd_ctrl_kept");

    // Req held high: one Ready every 3 cycles
    for (int i = 0; i < 3; i++) q0.push_back('{"held", 32'h1234_5678, 1'b0, 1'b1});
    drive(0, 1'b1, 1'b0, 32'h104, 32'h0);
    n = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (bus0.Ready) n++;
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("held_count", 32'(n), 32'd3);
    repeat (3) @(negedge clk);

    // Req toggled during WAIT/RESP is ignored
    q0.push_back('{"toggle", 32'h0000_00A5, 1'b0, 1'b1});
    drive(0, 1'b1, 1'b0, 32'h100, 32'h0);
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h104, 32'hFFFF_FFFF);
    @(negedge clk);
    n = bus0.Ready ? 1 : 0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus0.Ready) n++;
    end
    check("toggle_count", 32'(n), 32'd1);
    access(0, 0, 32'h104, 0, 32'h1234_5678, 0, "rd_scr_toggle");

    // Zero wait states
    access(1, 1, 32'h100, 32'hDEAD_BEA5, 0, 0, "ws0_wr_led");
    check("ws0_led_pins", {24'd0, test1}, 32'hA5);
    access(1, 0, 32'h100, 0, 32'h0000_00A5, 0, "ws0_rd_led");
    access(1, 0, 32'h118, 0, 32'h0, 1, "ws0_rd_unmap");

    // Reset during WAIT of an LED write
    drive(0, 1'b1, 1'b1, 32'h100, 32'h0000_003C);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_ready", {31'd0, bus0.Ready}, 32'd0);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus0.Ready) n++;
    end
    check("midrst_no_ready", 32'(n), 32'd0);
    check("midrst_led", {24'd0, test0}, 32'd0);
    access(0, 0, 32'h100, 0, 32'h0, 0, "post_rst_rd");
    access(0, 1, 32'h100, 32'h0000_0077, 0, 0, "post_rst_wr");
    check("post_rst_led", {24'd0, test0}, 32'h77);

    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mmio_responder.md
Name: mmio_responder

Overview:
- Memory-mapped peripheral responder on the processor data bus, alongside the instruction/data memory.
- Decodes a word-aligned address window and serves processor loads/stores through a req/ready handshake with configurable wait states.
- Holds a small register bank:
  - LED output register, driving the board `test[7:0]` pins.
  - Scratch register.
  - Free-running timer with compare, sticky match status and interrupt.

Parameters:
- DATA_WIDTH, 32, bus data width.
- ADDR_WIDTH, 32, bus address width.
- BASE_ADDR, 32'h0000_0100, window base; must be 64-byte aligned.
- WAIT_STATES, 1, extra cycles between request acceptance and Ready (0..15).

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous active-low reset.
- Req  input  1  access request, sampled only in IDLE.
- WE  input  1  1 = write, 0 = read; sampled with Req.
- Adr  input  ADDR_WIDTH  byte address; sampled with Req.
- WD  input  DATA_WIDTH  write data; sampled with Req.
- RD  output  DATA_WIDTH  read data, valid only while Ready=1.
- Ready  output  1  one-cycle completion pulse.
- Err  output  1  error flag, valid only with Ready.
- test  output  8  LED[7:0].
- Irq  output  1  timer interrupt, level.

Behaviour:
- Reset (RST=0, asynchronous):
  - FSM goes to IDLE; all registers clear to 0.
  - Outputs RD=0, Ready=0, Err=0, test=0, Irq=0.
  - A reset asserted mid-access aborts it: no write commits, no Ready.
- Register map (offset = Adr − BASE_ADDR):
  - 0x00 LED: RW, bits[7:0] only; reads zero-extended.
  - 0x04 SCRATCH: RW, full width.
  - 0x08 TIMER: RW; a write loads the value.
  - 0x0C CTRL: RW, bit0 TEN (timer enable), bit1 IEN (interrupt enable); other bits read 0.
  - 0x10 COMPARE: RW.
  - 0x14 STATUS: bit0 MATCH, sticky, write-1-to-clear; writing 0 has no effect.
- FSM states IDLE, WAIT, RESP:
  - IDLE: on Req=1, latch Adr/WE/WD and load the wait counter with WAIT_STATES. Go to RESP if WAIT_STATES=0, else WAIT.
  - WAIT: decrement the counter each cycle; go to RESP at counter = 1.
  - RESP: Ready=1 for exactly one cycle; the write commits at the end of this cycle. Return to IDLE.
  - Req is ignored outside IDLE. Req held high after Ready starts a new access, so back-to-back accesses are spaced 2+WAIT_STATES cycles apart.
- Latency: Req accepted at edge n → Ready high during cycle n+1+WAIT_STATES.
- Read data:
  - RD is registered and driven only during RESP; 0 otherwise.
  - RD reflects the register value at RESP entry (TIMER = value sampled on the RESP-entry edge).
- Errors: Err=1 with Ready, RD=0 and no state change when any of these hold:
  - address is outside [BASE_ADDR, BASE_ADDR+0x3F];
  - Adr[1:0] ≠ 0;
  - offset is unmapped (0x18..0x3C).
- Timer:
  - When TEN=1, increments by 1 per cycle, wrapping 2^32−1 → 0.
  - A software write to TIMER overrides the increment in that cycle.
  - MATCH sets on the cycle when TEN=1 and TIMER==COMPARE (pre-increment value).
- Simultaneous events:
  - MATCH set and a W1C in the same cycle: set wins.
  - A TIMER write and a match in the same cycle: the match is evaluated on the old value.
- Irq = MATCH & IEN, registered-free, combinational from flops.

Decomposition:
- Shared package holds:
  - register offset constants: OFF_LED, OFF_SCRATCH, OFF_TIMER, OFF_CTRL, OFF_COMPARE, OFF_STATUS;
  - FSM state encoding: IDLE=2'd0, WAIT=2'd1, RESP=2'd2;
  - CTRL bit positions.
- One sub-module, `mmio_timer`, contains:
  - the counter, compare, MATCH sticky and W1C logic;
  - load/clear strobes supplied by the responder FSM.
- All other logic stays in `mmio_responder`.

Test Plan:
- Reset then idle:
  - Expect test=0, Ready=0, Irq=0.
  - Read 0x100 → RD=0, Err=0, Ready exactly 2 cycles after Req (WAIT_STATES=1).
- Write 0x100 = 32'hDEAD_BEA5:
  - Expect test=8'hA5 after Ready.
  - Read back → RD=32'h0000_00A5.
  - Write/read SCRATCH 32'h1234_5678 → identical.
- Timer:
  - Write COMPARE=10, CTRL=1.
  - Expect STATUS read =1 after ≥11 cycles; Irq stays 0.
  - Set CTRL=3 → Irq=1.
  - Write STATUS=1 → Irq=0.
  - Load TIMER=32'hFFFF_FFFF → wraps to 0 next cycle.
- Errors:
  - Read 0x102 (misaligned), 0x118 (unmapped) and 0x200 (out of window) → each Err=1, RD=0.
  - Write 0x118 → no register changes.
- Handshake:
  - Hold Req high continuously → one Ready per 3 cycles.
  - Toggle Req during WAIT → ignored.
  - Rerun the write test with WAIT_STATES=0 → Ready 1 cycle after Req.
- Reset mid-access:
  - Assert RST low during WAIT of a write to LED.
  - Expect no Ready, test=0, FSM back in IDLE; the next access completes normally.
